// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle main controller: FSM states, opcodes, mux selects, trap causes.
// The extra states exist only when MC_CTRL_EXT_EN is defined.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXEC_R,
        S_EXEC_I,
        S_ALUWB,
        S_BEQ,
        S_JAL,
        S_TRAP
`ifdef MC_CTRL_EXT_EN
        , S_EXEC_U,
        S_JALR_T
`endif
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

endpackage

// File: rtl/mc_wait_timer.sv
// Counts consecutive cycles stalled on mem_ready in a memory state and flags the timeout cycle.
// TIMEOUT_CYCLES = 0 removes the counter and never times out.
module mc_wait_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic waiting,
    input  logic mem_ready,
    output logic timeout
);

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_timer
            localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
            logic [CNT_W-1:0] wait_cnt;

            // Saturates instead of wrapping; the FSM leaves before the limit is reached.
            always_ff @(posedge clk) begin
                if (rst || !waiting || mem_ready) begin
                    wait_cnt <= '0;
                end else if (wait_cnt != '1) begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
            end

            assign timeout = waiting && !mem_ready &&
                             (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
        end else begin : g_no_timer
            assign timeout = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/mc_main_controller.sv
// Multicycle Moore controller: fetch/decode/execute/memory/writeback with cache stalls and traps.
// Define MC_CTRL_EXT_EN to add lui, auipc and jalr support.
module mc_main_controller
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned IMM_SRC_W      = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           opcode,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 pc_write,
    output logic                 adr_src,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 ir_write,
    output logic                 reg_write,
    output logic                 branch,
    output logic [1:0]           alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           alu_op,
    output logic [1:0]           result_src,
    output logic [IMM_SRC_W-1:0] imm_src,
    output logic                 trap,
    output logic [1:0]           trap_cause
);

    state_t     state;
    logic [1:0] cause_q;
    logic       waiting;
    logic       timeout;
    logic [2:0] imm;

    assign waiting = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);

    mc_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wait_timer (
        .clk       (clk),
        .rst       (rst),
        .waiting   (waiting),
        .mem_ready (mem_ready),
        .timeout   (timeout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_FETCH;
            cause_q <= CAUSE_NONE;
        end else begin
            case (state)
                S_FETCH, S_MEMRD, S_MEMWR: begin
                    // mem_ready takes priority over a timeout in the same cycle
                    if (mem_ready) begin
                        state <= (state == S_FETCH) ? S_DECODE :
                                 (state == S_MEMRD) ? S_MEMWB  : S_FETCH;
                    end else if (timeout) begin
                        state   <= S_TRAP;
                        cause_q <= CAUSE_TIMEOUT;
                    end
                end
                S_DECODE: begin
                    case (opcode)
                        OP_LOAD, OP_STORE: state <= S_MEMADR;
                        OP_RTYPE:          state <= S_EXEC_R;
                        OP_ITYPE:          state <= S_EXEC_I;
                        OP_BRANCH:         state <= S_BEQ;
                        OP_JAL:            state <= S_JAL;
`ifdef MC_CTRL_EXT_EN
                        OP_LUI, OP_AUIPC:  state <= S_EXEC_U;
                        OP_JALR:           state <= S_JALR_T;
`endif
                        default: begin
                            state   <= S_TRAP;
                            cause_q <= CAUSE_ILLEGAL;
                        end
                    endcase
                end
                S_MEMADR:           state <= (opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
                S_EXEC_R, S_EXEC_I: state <= S_ALUWB;
                S_JAL:              state <= S_ALUWB;
                S_MEMWB, S_ALUWB:   state <= S_FETCH;
                S_BEQ:              state <= S_FETCH;
`ifdef MC_CTRL_EXT_EN
                S_EXEC_U:           state <= S_ALUWB;
                S_JALR_T:           state <= S_JAL;
`endif
                S_TRAP:             state <= S_TRAP;
                default:            state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        branch     = 1'b0;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALUOP_ADD;
        result_src = RES_ALUOUT;
        imm        = IMM_I;
        trap       = 1'b0;
        trap_cause = CAUSE_NONE;
        if (!rst) begin
            case (state)
                S_FETCH: begin
                    mem_read   = 1'b1;
                    ir_write   = mem_ready;
                    pc_write   = mem_ready;
                    alu_src_b  = SRCB_FOUR;
                    result_src = RES_ALU;
                end
                S_DECODE: begin
                    alu_src_a = SRCA_OLDPC;
                    alu_src_b = SRCB_IMM;
                    imm       = IMM_B;
                end
                S_MEMADR: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_IMM;
                    imm       = (opcode == OP_STORE) ? IMM_S : IMM_I;
                end
                S_MEMRD: begin
                    adr_src  = 1'b1;
                    mem_read = 1'b1;
                end
                S_MEMWB: begin
                    result_src = RES_RDATA;
                    reg_write  = 1'b1;
                end
                S_MEMWR: begin
                    adr_src   = 1'b1;
                    mem_write = 1'b1;
                end
                S_EXEC_R: begin
                    alu_src_a = SRCA_RS1;
                    alu_op    = ALUOP_FUNCT;
                end
                S_EXEC_I: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_IMM;
                    alu_op    = ALUOP_FUNCT;
                end
                S_ALUWB: reg_write = 1'b1;
                S_BEQ: begin
                    alu_src_a = SRCA_RS1;
                    alu_op    = ALUOP_SUB;
                    branch    = 1'b1;
                    pc_write  = zero;
                end
                S_JAL: begin
                    alu_src_a = SRCA_OLDPC;
                    alu_src_b = SRCB_FOUR;
                    pc_write  = 1'b1;
                end
`ifdef MC_CTRL_EXT_EN
                S_EXEC_U: begin
                    alu_src_a = (opcode == OP_AUIPC) ? SRCA_OLDPC : SRCA_ZERO;
                    alu_src_b = SRCB_IMM;
                    imm       = IMM_U;
                end
                S_JALR_T: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_IMM;
                end
`endif
                S_TRAP: begin
                    trap       = 1'b1;
                    trap_cause = cause_q;
                end
                default: ;
            endcase
        end
    end

    assign imm_src = IMM_SRC_W'(imm);

endmodule

// File: tb/tb_mc_main_controller.sv
// Directed bench for mc_main_controller with TIMEOUT_CYCLES=8; covers the MC_CTRL_EXT_EN build too.
module tb_mc_main_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] opcode = 7'b0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_write, adr_src, mem_read, mem_write, ir_write, reg_write, branch, trap;
    logic [1:0] alu_src_a, alu_src_b, alu_op, result_src, trap_cause;
    logic [2:0] imm_src;
    logic [20:0] obs;

    int unsigned total = 0;
    int unsigned passed = 0;

    mc_main_controller #(.TIMEOUT_CYCLES(8), .IMM_SRC_W(3)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .adr_src(adr_src), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_write(reg_write), .branch(branch),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .result_src(result_src), .imm_src(imm_src), .trap(trap), .trap_cause(trap_cause)
    );

    always #5 clk = ~clk;

    assign obs = {pc_write, adr_src, mem_read, mem_write, ir_write, reg_write, branch,
                  alu_src_a, alu_src_b, alu_op, result_src, imm_src, trap, trap_cause};

    function automatic logic [20:0] ctl(input logic pcw, adr, mrd, mwr, irw, rw, br,
                                        input logic [1:0] a, b, op, rs,
                                        input logic [2:0] imm,
                                        input logic tr, input logic [1:0] cause);
        return {pcw, adr, mrd, mwr, irw, rw, br, a, b, op, rs, imm, tr, cause};
    endfunction

    task automatic check(input string tag, input logic [20:0] exp);
        #1;
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    logic [20:0] zeros, f_rdy, f_wait, dec, madr_lw, madr_sw, memrd, memwb, memwr;
    logic [20:0] exec_r, exec_i, aluwb, beq_t, beq_n, jal_s, trap01, trap10;
`ifdef MC_CTRL_EXT_EN
    logic [20:0] exec_lui;
`endif

    initial begin
        #100000;
        $display("FAIL watchdog expired before end of sequence");
        $fatal(1, "timeout");
    end

    initial begin
        zeros   = '0;
        f_rdy   = ctl(1,0,1,0,1,0,0, 2'b00,2'b10,2'b00,2'b10, 3'b000, 0,2'b00);
        f_wait  = ctl(0,0,1,0,0,0,0, 2'b00,2'b10,2'b00,2'b10, 3'b000, 0,2'b00);
        dec     = ctl(0,0,0,0,0,0,0, 2'b01,2'b01,2'b00,2'b00, 3'b010, 0,2'b00);
        madr_lw = ctl(0,0,0,0,0,0,0, 2'b10,2'b01,2'b00,2'b00, 3'b000, 0,2'b00);
        madr_sw = ctl(0,0,0,0,0,0,0, 2'b10,2'b01,2'b00,2'b00, 3'b001, 0,2'b00);
        memrd   = ctl(0,1,1,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 0,2'b00);
        memwb   = ctl(0,0,0,0,0,1,0, 2'b00,2'b00,2'b00,2'b01, 3'b000, 0,2'b00);
        memwr   = ctl(0,1,0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 0,2'b00);
        exec_r  = ctl(0,0,0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00, 3'b000, 0,2'b00);
        exec_i  = ctl(0,0,0,0,0,0,0, 2'b10,2'b01,2'b10,2'b00, 3'b000, 0,2'b00);
        aluwb   = ctl(0,0,0,0,0,1,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 0,2'b00);
        beq_t   = ctl(1,0,0,0,0,0,1, 2'b10,2'b00,2'b01,2'b00, 3'b000, 0,2'b00);
        beq_n   = ctl(0,0,0,0,0,0,1, 2'b10,2'b00,2'b01,2'b00, 3'b000, 0,2'b00);
        jal_s   = ctl(1,0,0,0,0,0,0, 2'b01,2'b10,2'b00,2'b00, 3'b000, 0,2'b00);
        trap01  = ctl(0,0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 1,2'b01);
        trap10  = ctl(0,0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 1,2'b10);
`ifdef MC_CTRL_EXT_EN
        exec_lui = ctl(0,0,0,0,0,0,0, 2'b11,2'b01,2'b00,2'b00, 3'b100, 0,2'b00);
`endif

        // reset: outputs forced low
        rst = 1'b1; mem_ready = 1'b1; opcode = 7'b0110011;
        tick; tick;
        check("reset_outputs", zeros);
        rst = 1'b0;

        // add x3,x1,x2
        check("add_fetch", f_rdy);   tick;
        check("add_decode", dec);    tick;
        check("add_exec_r", exec_r); tick;
        check("add_aluwb", aluwb);   tick;

        // lw with 5 stall cycles in MEMRD
        opcode = 7'b0000011;
        check("lw_fetch", f_rdy);     tick;
        check("lw_decode", dec);      tick;
        check("lw_memadr", madr_lw);  tick;
        mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("lw_memrd_wait", memrd); tick;
        end
        mem_ready = 1'b1;
        check("lw_memrd_done", memrd); tick;
        check("lw_memwb", memwb);      tick;

        // sw with 3 stall cycles in MEMWR
        opcode = 7'b0100011;
        check("sw_fetch", f_rdy);     tick;
        check("sw_decode", dec);      tick;
        check("sw_memadr", madr_sw);  tick;
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("sw_memwr_wait", memwr); tick;
        end
        mem_ready = 1'b1;
        check("sw_memwr_done", memwr); tick;

        // beq taken then not taken
        opcode = 7'b1100011; zero = 1'b1;
        check("beq1_fetch", f_rdy); tick;
        check("beq1_decode", dec);  tick;
        check("beq_taken", beq_t);  tick;
        zero = 1'b0;
        check("beq2_fetch", f_rdy); tick;
        check("beq2_decode", dec);  tick;
        check("beq_not_taken", beq_n); tick;

        // jal
        opcode = 7'b1101111;
        check("jal_fetch", f_rdy);  tick;
        check("jal_decode", dec);   tick;
        check("jal_state", jal_s);  tick;
        check("jal_aluwb", aluwb);  tick;

        // addi
        opcode = 7'b0010011;
        check("addi_fetch", f_rdy);   tick;
        check("addi_decode", dec);    tick;
        check("addi_exec_i", exec_i); tick;
        check("addi_aluwb", aluwb);   tick;

        // fetch stall of 7 cycles, ready arrives on the would-be timeout cycle
        opcode = 7'b0110011; mem_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            check("fetch_stall", f_wait); tick;
        end
        mem_ready = 1'b1;
        check("fetch_ready_wins", f_rdy); tick;
        check("stall_decode", dec);       tick;
        check("stall_exec_r", exec_r);    tick;
        check("stall_aluwb", aluwb);      tick;

        // lui: extension path or illegal opcode
        opcode = 7'b0110111;
        check("lui_fetch", f_rdy); tick;
        check("lui_decode", dec);  tick;
`ifdef MC_CTRL_EXT_EN
        check("lui_exec_u", exec_lui); tick;
        check("lui_aluwb", aluwb);     tick;
`else
        check("lui_trap", trap01); tick;
        rst = 1'b1; tick; rst = 1'b0;
`endif

        // generic illegal opcode, trap is sticky until reset
        opcode = 7'b1111111;
        check("ill_fetch", f_rdy);  tick;
        check("ill_decode", dec);   tick;
        check("ill_trap", trap01);  tick;
        mem_ready = 1'b0;
        tick;
        check("ill_trap_sticky", trap01);
        rst = 1'b1;
        check("ill_rst_override", zeros); tick;
        rst = 1'b0;

        // timeout: mem_ready stuck low in FETCH
        for (int i = 0; i < 8; i++) begin
            check("to_fetch_wait", f_wait); tick;
        end
        check("to_trap", trap10); tick;
        check("to_trap_sticky", trap10);
        rst = 1'b1;
        check("to_rst_override", zeros); tick;
        rst = 1'b0;
        check("to_post_reset_fetch", f_wait);
        mem_ready = 1'b1;
        check("to_post_reset_ready", f_rdy); tick;
        check("to_post_reset_decode", dec);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mc_main_controller.md
Name: mc_main_controller

Overview:
- Multicycle successor to the single-cycle main decoder in the RISC-V core.
- One Moore FSM sequences fetch, decode, execute, memory and writeback over several cycles, and emits per-cycle datapath controls.
- Stalls on the cache handshake (mem_ready) so cache misses and write-through stores are absorbed without datapath changes.
- Adds trap detection (illegal opcode, memory timeout). Sits between the instruction register opcode field and the shared ALU/PC/register-file datapath.

Parameters:
- TIMEOUT_CYCLES, 256: maximum consecutive cycles waiting on mem_ready in any memory state before trapping; 0 disables the timeout.
- IMM_SRC_W, 3: width of imm_src; must be at least 3.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- opcode  in  7  instr[6:0], taken from the instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  cache access complete: read data valid, or write accepted
- pc_write  out  1  PC load strobe
- adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  out  1  cache read request
- mem_write  out  1  cache write request
- ir_write  out  1  instruction register / oldPC load
- reg_write  out  1  register file write enable
- branch  out  1  branch state indicator
- alu_src_a  out  2  ALU A select: 00 = PC, 01 = oldPC, 10 = rs1, 11 = zero
- alu_src_b  out  2  ALU B select: 00 = rs2, 01 = imm, 10 = constant 4
- alu_op  out  2  ALU operation: 00 = add, 01 = sub, 10 = funct-decoded
- result_src  out  2  result select: 00 = ALUOut, 01 = read data, 10 = ALU result
- imm_src  out  IMM_SRC_W  immediate type: 000 = I, 001 = S, 010 = B, 011 = J, 100 = U
- trap  out  1  sticky trap flag
- trap_cause  out  2  01 = illegal opcode, 10 = timeout, 00 = none

Behaviour:
- Reset: one clock is synchronous and reset is active-high.
  - rst high at a clock edge sets state to FETCH and clears wait_cnt, trap and trap_cause.
  - While rst is high, all outputs are forced to 0, overriding any state.
  - Reset mid-access abandons the cache request with no further strobes.
- Outputs are combinational from state, with mem_ready/zero gating strobes only. Any control not listed for a state is 0.
- FETCH:
  - Controls: mem_read=1, adr_src=0, a=00, b=10, alu_op=00, result_src=10.
  - ir_write and pc_write are asserted only in the cycle mem_ready=1; the FSM then moves to DECODE, otherwise it stays in FETCH.
- DECODE:
  - Controls: a=01, b=01, alu_op=00, imm_src=010 (branch target into ALUOut).
  - Next state by opcode:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXEC_R
    - 0010011 → EXEC_I
    - 1100011 → BEQ
    - 1101111 → JAL
    - anything else → TRAP with cause 01
- MEMADR:
  - Controls: a=10, b=01, alu_op=00; imm_src=000 for lw, 001 for sw.
  - Next state: lw → MEMRD, sw → MEMWR.
- MEMRD: adr_src=1, mem_read=1; holds until mem_ready, then → MEMWB.
- MEMWB: result_src=01, reg_write=1 → FETCH.
- MEMWR: adr_src=1, mem_write=1; held high until mem_ready, then → FETCH (write-through stall).
- EXEC_R: a=10, b=00, alu_op=10 → ALUWB.
- EXEC_I: a=10, b=01, imm_src=000, alu_op=10 → ALUWB.
- ALUWB: result_src=00, reg_write=1 → FETCH.
- BEQ: a=10, b=00, alu_op=01, result_src=00, branch=1, pc_write=zero → FETCH.
- JAL: a=01, b=10, alu_op=00, result_src=00, pc_write=1 → ALUWB (rd = oldPC+4).
- Timeout counter (wait_cnt):
  - Increments each cycle spent in FETCH, MEMRD or MEMWR with mem_ready=0.
  - Clears on mem_ready=1 or on leaving the state.
  - If TIMEOUT_CYCLES>0 and wait_cnt==TIMEOUT_CYCLES-1 with mem_ready=0 → TRAP with cause 10.
  - If mem_ready=1 arrives in that same cycle, mem_ready wins.
- TRAP: all controls 0; trap=1; trap_cause holds. Exit only via rst.
- Counter width is $clog2(TIMEOUT_CYCLES+1); it must not wrap.

Optional Feature:
- Macro: MC_CTRL_EXT_EN.
- Defined: DECODE additionally accepts three opcodes.
  - 0110111 lui → EXEC_U: a=11, b=01, imm_src=100, alu_op=00 → ALUWB.
  - 0010111 auipc → EXEC_U with a=01 → ALUWB.
  - 1100111 jalr → JALR_T: a=10, b=01, imm_src=000, alu_op=00 → JAL. JAL then loads PC from ALUOut and writes rd = oldPC+4.
- Undefined: these three opcodes trap with cause 01; the states are absent.

Decomposition:
- Package mc_ctrl_pkg holds:
  - the state enum
  - opcode constants (OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL, OP_LUI, OP_AUIPC, OP_JALR)
  - alu_src_a/alu_src_b/result_src/imm_src/alu_op encodings
  - trap cause codes
- One sub-module, mc_wait_timer, holds the wait_cnt counter and timeout compare.

Test Plan:
- add x3,x1,x2 with mem_ready tied 1 → FETCH, DECODE, EXEC_R, ALUWB; reg_write=1 in cycle 4 only; pc_write once.
- lw with mem_ready low 5 cycles in MEMRD → mem_read held 6 cycles, adr_src=1; reg_write in the MEMWB cycle that follows.
- sw with mem_ready delayed 3 cycles → mem_write high exactly 4 cycles; no reg_write.
- beq with zero=1, then with zero=0 → pc_write=1 / pc_write=0 in the BEQ cycle; branch=1 both times.
- TIMEOUT_CYCLES=8, mem_ready stuck 0 in FETCH → TRAP after 8 cycles; trap_cause=10; rst restores FETCH with outputs 0.
- opcode 0110111 → trap_cause=01 without the macro; with MC_CTRL_EXT_EN, reg_write in ALUWB with a=11, imm_src=100.
